multi_cycle: RTL and testbench

16-bit multicycle RISC processor core (RISC24-style ISA subset) with internal instruction ROM, data RAM, 8x16 register file, PC and carry/zero flags. Every instruction takes exactly four cycles through FETCH, DECODE, EXECUTE, WRITEBACK. Internal datapath signals are exported as ports for bench observation.

---
 rtl/multi_cycle.sv | 197 +++++++++++++++++++
 tb/tb_multi_cycle.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle.sv
// rtl/multi_cycle.sv - 16-bit four-state multicycle RISC core (optional CZ_COND_EN: cz-conditional execution)
module multi_cycle #(
    parameter string IMEM_FILE = "program.hex",
    parameter int    MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] writedata,
    output logic [15:0] dataaddr,
    output logic        memwrite,
    output logic [15:0] instr,
    output logic [15:0] srca,
    output logic [15:0] srcb,
    output logic [15:0] result,
    output logic [15:0] aluout,
    output logic [1:0]  state,
    output logic        zero,
    output logic        carry
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [3:0] OP_ADI  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1000;

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    state_t      cur_state;
    state_t      nxt_state;
    logic [15:0] pc;
    logic [15:0] regs [8];
    logic [15:0] imem [MEM_DEPTH];
    logic [15:0] dmem [MEM_DEPTH];
    logic        alu_c;
    logic        cond_ok;
    logic        cin;
    logic [16:0] sum17;
    logic [15:0] rdata;

    logic [3:0]  op;
    logic [2:0]  ra_f;
    logic [2:0]  rb_f;
    logic [2:0]  rc_f;
    logic        comp;
    logic [1:0]  cz;
    logic [15:0] imm_sx;

    assign op     = instr[15:12];
    assign ra_f   = instr[11:9];
    assign rb_f   = instr[8:6];
    assign rc_f   = instr[5:3];
    assign comp   = instr[2];
    assign cz     = instr[1:0];
    assign imm_sx = {{10{instr[5]}}, instr[5:0]};

    assign state     = cur_state;
    assign writedata = regs[ra_f];
    assign dataaddr  = aluout;
    assign memwrite  = (cur_state == S_WRITEBACK) && (op == OP_SW);
    assign rdata     = dmem[aluout[AW-1:0]];

    // Decide whether an ADD/NAND-family instruction actually executes; flags only move in writeback,
    // so they are stable for the whole instruction
    always_comb begin
        cond_ok = 1'b0;
        case (cz)
            2'b00: cond_ok = 1'b1;
`ifdef CZ_COND_EN
            2'b10: cond_ok = carry;
            2'b01: cond_ok = zero;
`else
            2'b10: cond_ok = 1'b1;
            2'b01: cond_ok = 1'b1;
`endif
            default: cond_ok = (op == OP_ADD);
        endcase
    end

    // Adder with carry-in only for the add-with-carry encoding
    always_comb begin
        cin   = (op == OP_ADD) && (cz == 2'b11) && carry;
        sum17 = {1'b0, srca} + {1'b0, srcb} + {16'd0, cin};
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_state <= S_FETCH;
        else        cur_state <= nxt_state;
    end

    // Fixed four-step sequence, one instruction per lap
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_FETCH:     nxt_state = S_DECODE;
            S_DECODE:    nxt_state = S_EXECUTE;
            S_EXECUTE:   nxt_state = S_WRITEBACK;
            S_WRITEBACK: nxt_state = S_FETCH;
            default:     nxt_state = S_FETCH;
        endcase
    end

    // Datapath: each state owns its own set of registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= 16'd0;
            instr  <= 16'd0;
            srca   <= 16'd0;
            srcb   <= 16'd0;
            aluout <= 16'd0;
            result <= 16'd0;
            alu_c  <= 1'b0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
        end else begin
            case (cur_state)
                S_FETCH: instr <= imem[pc[AW-1:0]];
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: begin
                            srca <= regs[rb_f];
                            srcb <= imm_sx;
                        end
                        OP_ADI: begin
                            srca <= regs[ra_f];
                            srcb <= imm_sx;
                        end
                        OP_ADD, OP_NAND: begin
                            srca <= regs[ra_f];
                            srcb <= comp ? ~regs[rb_f] : regs[rb_f];
                        end
                        default: begin
                            srca <= regs[ra_f];
                            srcb <= regs[rb_f];
                        end
                    endcase
                end
                S_EXECUTE: begin
                    case (op)
                        OP_NAND: begin
                            aluout <= ~(srca & srcb);
                            alu_c  <= 1'b0;
                        end
                        OP_BEQ: begin
                            aluout <= pc + imm_sx;
                            alu_c  <= 1'b0;
                        end
                        default: {alu_c, aluout} <= sum17;
                    endcase
                end
                default: begin
                    pc <= pc + 16'd1;
                    case (op)
                        OP_ADD: if (cond_ok) begin
                            regs[rc_f] <= aluout;
                            result     <= aluout;
                            carry      <= alu_c;
                            zero       <= (aluout == 16'd0);
                        end
                        OP_NAND: if (cond_ok) begin
                            regs[rc_f] <= aluout;
                            result     <= aluout;
                            zero       <= (aluout == 16'd0);
                        end
                        OP_ADI: begin
                            regs[rb_f] <= aluout;
                            result     <= aluout;
                            carry      <= alu_c;
                            zero       <= (aluout == 16'd0);
                        end
                        OP_LW: begin
                            regs[ra_f] <= rdata;
                            result     <= rdata;
                            zero       <= (rdata == 16'd0);
                        end
                        OP_BEQ: if (srca == srcb) pc <= aluout;
                        default: ;
                    endcase
                end
            endcase
        end
    end

    // Data RAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (memwrite) dmem[aluout[AW-1:0]] <= writedata;
    end
endmodule

// File: tb/tb_multi_cycle.sv
// tb/tb_multi_cycle.sv - directed self-checking bench for multi_cycle
module tb_multi_cycle;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] writedata, dataaddr, instr, srca, srcb, result, aluout;
    logic        memwrite, zero, carry;
    logic [1:0]  state;
    int          checks = 0;
    int          errors = 0;

    multi_cycle #(.IMEM_FILE(""), .MEM_DEPTH(256)) dut (
        .clk(clk), .reset(reset), .writedata(writedata), .dataaddr(dataaddr),
        .memwrite(memwrite), .instr(instr), .srca(srca), .srcb(srcb),
        .result(result), .aluout(aluout), .state(state), .zero(zero), .carry(carry)
    );

    always #5 clk = ~clk;

    task hold_reset;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.imem[i] = 16'h3000;
    endtask

    task release_reset;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task run_instrs(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    task test_reset;
        logic [1:0] exp_state;
        #1 reset = 1'b0;
        for (int i = 0; i < 256; i++) dut.imem[i] = 16'h3000;
        dut.imem[0] = 16'h22a0;
        dut.imem[1] = 16'h2848;
        #1;
        checks++;
        if ({state, instr, srca, srcb, aluout, result, zero, carry, memwrite} !== 85'd0) begin
            errors++;
            $display("FAIL reset_outputs got state=%0d instr=%h srca=%h srcb=%h aluout=%h result=%h z=%b c=%b mw=%b want all 0",
                     state, instr, srca, srcb, aluout, result, zero, carry, memwrite);
        end
        #19 reset = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_state = 2'(i % 4);
            checks++;
            if (state !== exp_state) begin
                errors++;
                $display("FAIL state_seq[%0d] got %0d want %0d", i, state, exp_state);
            end
            if (i == 4) begin
                checks++;
                if (dut.regs[4] !== 16'hffff || result !== 16'hffff || zero !== 1'b0) begin
                    errors++;
                    $display("FAIL nand_first got R4=%h result=%h zero=%b want ffff ffff 0", dut.regs[4], result, zero);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dut.regs[1] !== 16'hffff) begin
            errors++;
            $display("FAIL nand_second got R1=%h want ffff", dut.regs[1]);
        end
    endtask

    task test_add;
        hold_reset();
        dut.imem[0] = 16'h0045;
        dut.imem[1] = 16'h1258;
        release_reset();
        run_instrs(2);
        checks++;
        if (dut.regs[1] !== 16'h0005 || dut.regs[3] !== 16'h000a || carry !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL add_basic got R1=%h R3=%h c=%b z=%b want 0005 000a 0 0", dut.regs[1], dut.regs[3], carry, zero);
        end
    endtask

    task test_cond;
        logic [15:0] exp_r4;
`ifdef CZ_COND_EN
        exp_r4 = 16'h0000;
`else
        exp_r4 = 16'hfffe;
`endif
        hold_reset();
        dut.imem[0] = 16'h007f;
        dut.imem[1] = 16'h1250;
        dut.imem[2] = 16'h125a;
        dut.imem[3] = 16'h1261;
        dut.imem[4] = 16'h102b;
        release_reset();
        run_instrs(2);
        checks++;
        if (dut.regs[1] !== 16'hffff || dut.regs[2] !== 16'hfffe || carry !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL add_carry got R1=%h R2=%h c=%b z=%b want ffff fffe 1 0", dut.regs[1], dut.regs[2], carry, zero);
        end
        run_instrs(1);
        checks++;
        if (dut.regs[3] !== 16'hfffe) begin
            errors++;
            $display("FAIL adc_exec got R3=%h want fffe", dut.regs[3]);
        end
        run_instrs(1);
        checks++;
        if (dut.regs[4] !== exp_r4 || carry !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL adz_cond got R4=%h c=%b z=%b want %h 1 0", dut.regs[4], carry, zero, exp_r4);
        end
        run_instrs(1);
        checks++;
        if (dut.regs[5] !== 16'h0001 || carry !== 1'b0) begin
            errors++;
            $display("FAIL add_cin got R5=%h c=%b want 0001 0", dut.regs[5], carry);
        end
    endtask

    task test_sw_lw;
        int          mw_cnt;
        logic [15:0] cap_addr, cap_data;
        mw_cnt   = 0;
        cap_addr = 16'hxxxx;
        cap_data = 16'hxxxx;
        hold_reset();
        dut.imem[0] = 16'h0055;
        dut.imem[1] = 16'h5203;
        dut.imem[2] = 16'h4a03;
        release_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (memwrite === 1'b1) begin
                mw_cnt++;
                cap_addr = dataaddr;
                cap_data = writedata;
            end
        end
        checks++;
        if (mw_cnt != 1) begin
            errors++;
            $display("FAIL sw_strobe got %0d cycles want 1", mw_cnt);
        end
        checks++;
        if (cap_addr !== 16'h0003 || cap_data !== 16'h0015) begin
            errors++;
            $display("FAIL sw_bus got addr=%h data=%h want 0003 0015", cap_addr, cap_data);
        end
        checks++;
        if (dut.regs[5] !== 16'h0015 || result !== 16'h0015 || zero !== 1'b0) begin
            errors++;
            $display("FAIL lw_data got R5=%h result=%h z=%b want 0015 0015 0", dut.regs[5], result, zero);
        end
    endtask

    task test_beq;
        hold_reset();
        dut.imem[0] = 16'h8042;
        dut.imem[1] = 16'h0087;
        dut.imem[2] = 16'h0041;
        dut.imem[3] = 16'h8042;
        release_reset();
        run_instrs(1);
        checks++;
        if (dut.pc !== 16'h0002) begin
            errors++;
            $display("FAIL beq_taken got pc=%h want 0002", dut.pc);
        end
        run_instrs(2);
        checks++;
        if (dut.pc !== 16'h0004 || dut.regs[1] !== 16'h0001 || dut.regs[2] !== 16'h0000) begin
            errors++;
            $display("FAIL beq_not_taken got pc=%h R1=%h R2=%h want 0004 0001 0000", dut.pc, dut.regs[1], dut.regs[2]);
        end
    endtask

    task test_reset_mid;
        hold_reset();
        dut.imem[0] = 16'h0045;
        dut.imem[1] = 16'h0087;
        release_reset();
        run_instrs(1);
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 2'd2 || dut.regs[1] !== 16'h0005) begin
            errors++;
            $display("FAIL mid_pre got state=%0d R1=%h want 2 0005", state, dut.regs[1]);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({state, instr, srca, srcb, aluout, result, zero, carry, memwrite} !== 85'd0 ||
            dut.pc !== 16'd0 || dut.regs[1] !== 16'd0 || dut.regs[2] !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got state=%0d instr=%h aluout=%h result=%h pc=%h R1=%h R2=%h want all 0",
                     state, instr, aluout, result, dut.pc, dut.regs[1], dut.regs[2]);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (dut.regs[2] !== 16'd0 || state !== 2'd0) begin
            errors++;
            $display("FAIL mid_hold got R2=%h state=%0d want 0000 0", dut.regs[2], state);
        end
        release_reset();
        run_instrs(2);
        checks++;
        if (dut.pc !== 16'h0002 || dut.regs[1] !== 16'h0005 || dut.regs[2] !== 16'h0007) begin
            errors++;
            $display("FAIL mid_restart got pc=%h R1=%h R2=%h want 0002 0005 0007", dut.pc, dut.regs[1], dut.regs[2]);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cond();
        test_sw_lw();
        test_beq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
